// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, TX FSM encoding and baud helper
package uart_pkg;

    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_ODD  = 1;
    localparam int UART_PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Clock cycles per bit, truncated
    function automatic int bps_cnt(input int clk, input int bps);
        return clk / bps;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous first-word-fall-through FIFO
// Writes when full and reads when empty are ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with transmit FIFO
// Frames leave back-to-back while the FIFO holds data.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 65_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int BW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (BPS_CNT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < UART_PAR_NONE || PARITY > UART_PAR_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $fatal(1, "uart_tx_param: parameter out of range");
    end

    tx_state_t              state_q, state_n;
    logic [BW-1:0]          baud_q, baud_n;
    logic [3:0]             bit_q, bit_n;
    logic [DATA_BITS-1:0]   sh_q, sh_n;
    logic                   par_q, par_n;
    logic                   txd_q, txd_n;
    logic                   pop;
    logic                   baud_end;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   unused_tx_data;

    assign unused_tx_data = ^tx_data;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (tx_valid),
        .wr_data (tx_data[DATA_BITS-1:0]),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_end = (baud_q == BAUD_LAST);
    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_txd = txd_q;

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        par_n   = par_q;
        pop     = 1'b0;
        txd_n   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_n = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_q + 4'd1;
                        sh_n  = sh_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        // Chain straight into the next start bit when data waits
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || baud_end) baud_n = '0;
        else                                baud_n = baud_q + BW'(1);

        if (state_n != state_q || state_q == ST_IDLE) bit_n = '0;

        if (pop) begin
            sh_n  = fifo_rd_data;
            par_n = (PARITY == UART_PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
        end

        // Line value is registered, so it follows the upcoming state
        case (state_n)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = sh_n[0];
            ST_PARITY: txd_n = par_n;
            default:   txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            par_q   <= par_n;
            txd_q   <= txd_n;
        end
    end

endmodule
